// File: rtl/l1d_cache_pkg.sv
// Shared types and helpers for the set-associative L1 data cache.
// FLUSH state exists only when L1D_FLUSH_EN is defined.
package l1d_cache_pkg;

    typedef enum logic [1:0] {
        COP_RD   = 2'd0,
        COP_WR   = 2'd1,
        COP_RDNC = 2'd2,
        COP_WRNC = 2'd3
    } cop_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_WTHRU,
        S_NC
`ifdef L1D_FLUSH_EN
        , S_FLUSH
`endif
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    function automatic logic [3:0] be_from_size(input logic [1:0] size,
                                                input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m << off;
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) r = r | 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/l1d_plru.sv
// Tree pseudo-LRU state, WAYS-1 bits per set; a touch points away from the way.
module l1d_plru #(
    parameter int WAYS = 4,
    parameter int SETS = 64,
    localparam int IW = $clog2(SETS),
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic          clk,
    input  logic          i_clr_all,
    input  logic [IW-1:0] i_idx,
    input  logic          i_touch_val,
    input  logic [WW-1:0] i_touch_way,
    input  logic          i_clr_val,
    input  logic [IW-1:0] i_clr_idx,
    output logic [WW-1:0] o_victim_way
);

    if (WAYS == 1) begin : g_dm
        assign o_victim_way = '0;
    end else begin : g_tree
        localparam int LV = $clog2(WAYS);

        logic [WAYS-2:0] r_tree [SETS];
        logic [WAYS-2:0] w_cur;
        logic [WAYS-2:0] w_upd;
        logic [WW-1:0]   w_vic;

        // Heap-ordered nodes: bit 0 steers the victim left, 1 right.
        always_comb begin
            int n;
            w_cur = r_tree[i_idx];
            w_upd = w_cur;
            w_vic = '0;
            n = 0;
            for (int l = 0; l < LV; l++) begin
                w_vic[LV-1-l] = w_cur[n];
                n = 2 * n + 1 + int'(w_cur[n]);
            end
            n = 0;
            for (int l = 0; l < LV; l++) begin
                w_upd[n] = ~i_touch_way[LV-1-l];
                n = 2 * n + 1 + int'(i_touch_way[LV-1-l]);
            end
        end

        assign o_victim_way = w_vic;

        always_ff @(posedge clk) begin
            if (i_clr_all) begin
                for (int s = 0; s < SETS; s++)
                    r_tree[s] <= '0;
            end else if (i_clr_val) begin
                r_tree[i_clr_idx] <= '0;
            end else if (i_touch_val) begin
                r_tree[i_idx] <= w_upd;
            end
        end
    end

endmodule

// File: rtl/l1d_cache_sa.sv
// Set-associative write-through, no-write-allocate L1 data cache with NC bypass.
// Define L1D_FLUSH_EN to add flush_req/flush_done and a set-walking flush.
module l1d_cache_sa
    import l1d_cache_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef L1D_FLUSH_EN
    input  logic                    flush_req,
    output logic                    flush_done,
`endif
    input  logic                    core_req_val,
    input  logic [ADDR_W-1:0]       core_req_addr,
    input  logic [1:0]              core_req_cop,
    input  logic [31:0]             core_req_wdata,
    input  logic [1:0]              core_req_size,
    output logic                    core_req_ack,
    output logic [31:0]             core_ack_data,
    output logic                    mau_req_val,
    output logic                    mau_req_nc,
    output logic                    mau_req_we,
    output logic [ADDR_W-1:0]       mau_req_addr,
    output logic [31:0]             mau_req_wdata,
    output logic [3:0]              mau_req_be,
    input  logic                    mau_req_ack,
    input  logic [LINE_BYTES*8-1:0] mau_ack_data
);

    localparam int OW  = $clog2(LINE_BYTES);
    localparam int IW  = $clog2(SETS);
    localparam int TW  = ADDR_W - IW - OW;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LB  = LINE_BYTES * 8;
    localparam int WPL = LINE_BYTES / 4;
    localparam int SW  = (WPL > 1) ? $clog2(WPL) : 1;

    logic [SETS-1:0] r_valid [WAYS];
    logic [TW-1:0]   r_tag   [WAYS][SETS];
    logic [LB-1:0]   r_data  [WAYS][SETS];

    state_e          r_state;
    state_e          w_nxt;
    logic [WAYS-1:0] r_hit_vec;
    logic [WAYS-1:0] r_inv_vec;
    logic [WW-1:0]   r_way;
    logic            r_hit;

    logic [IW-1:0]   w_idx;
    logic [TW-1:0]   w_tag;
    logic [SW-1:0]   w_wsel;
    cop_e            w_cop;
    logic [3:0]      w_be;
    logic [WAYS-1:0] w_hit_vec;
    logic [WAYS-1:0] w_inv_vec;
    logic [WW-1:0]   w_hit_way;
    logic [WW-1:0]   w_inv_way;
    logic            w_inv_any;
    logic [WW-1:0]   w_plru_vic;
    logic [WW-1:0]   w_victim;
    logic [WW-1:0]   w_touch_way;
    logic [LB-1:0]   w_hit_line;
    logic [31:0]     w_hit_word;
    logic [31:0]     w_mau_word;
    logic            w_touch;
    logic            w_fill;
    logic            w_wr_hit;
    logic            w_clr_val;
    logic [IW-1:0]   w_clr_idx;

    assign w_idx  = core_req_addr[OW +: IW];
    assign w_tag  = core_req_addr[OW+IW +: TW];
    assign w_wsel = SW'((core_req_addr >> 2) & ADDR_W'(WPL - 1));
    assign w_cop  = cop_e'(core_req_cop);
    assign w_be   = be_from_size(core_req_size, core_req_addr[1:0]);

    always_comb begin
        w_hit_vec = '0;
        w_inv_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
            w_inv_vec[w] = !r_valid[w][w_idx];
        end
    end

    always_comb begin
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_inv_vec[w]) begin
                w_inv_any = 1'b1;
                w_inv_way = WW'(w);
            end
        end
    end

    assign w_hit_way   = WW'(onehot_to_idx(8'(r_hit_vec)));
    assign w_victim    = w_inv_any ? w_inv_way : w_plru_vic;
    assign w_touch_way = (r_state == S_LOOKUP) ? w_hit_way : r_way;
    assign w_hit_line  = r_data[w_hit_way][w_idx];
    assign w_hit_word  = w_hit_line[32*w_wsel +: 32];
    assign w_mau_word  = mau_ack_data[32*w_wsel +: 32];

`ifdef L1D_FLUSH_EN
    logic [IW-1:0] r_fidx;
    assign w_clr_val = (r_state == S_FLUSH);
    assign w_clr_idx = r_fidx;
`else
    assign w_clr_val = 1'b0;
    assign w_clr_idx = '0;
`endif

    always_comb begin
        w_nxt         = r_state;
        core_req_ack  = 1'b0;
        core_ack_data = '0;
        mau_req_val   = 1'b0;
        mau_req_nc    = 1'b0;
        mau_req_we    = 1'b0;
        mau_req_addr  = '0;
        mau_req_wdata = '0;
        mau_req_be    = '0;
        w_touch       = 1'b0;
        w_fill        = 1'b0;
        w_wr_hit      = 1'b0;
`ifdef L1D_FLUSH_EN
        flush_done    = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
`ifdef L1D_FLUSH_EN
                if (flush_req)
                    w_nxt = S_FLUSH;
                else
`endif
                if (core_req_val)
                    w_nxt = (w_cop == COP_RD || w_cop == COP_WR) ?
                            S_LOOKUP : S_NC;
            end
            S_LOOKUP: begin
                if (w_cop == COP_RD) begin
                    if (|r_hit_vec) begin
                        core_req_ack  = 1'b1;
                        core_ack_data = w_hit_word;
                        w_touch       = 1'b1;
                        w_nxt         = S_IDLE;
                    end else begin
                        w_nxt = S_REFILL;
                    end
                end else begin
                    w_nxt = S_WTHRU;
                end
            end
            S_REFILL: begin
                mau_req_val   = 1'b1;
                mau_req_addr  = {core_req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                mau_req_wdata = core_req_wdata;
                mau_req_be    = w_be;
                if (mau_req_ack) begin
                    w_fill        = 1'b1;
                    w_touch       = 1'b1;
                    core_req_ack  = 1'b1;
                    core_ack_data = w_mau_word;
                    w_nxt         = S_IDLE;
                end
            end
            S_WTHRU: begin
                mau_req_val   = 1'b1;
                mau_req_we    = 1'b1;
                mau_req_addr  = {core_req_addr[ADDR_W-1:2], 2'b00};
                mau_req_wdata = core_req_wdata;
                mau_req_be    = w_be;
                if (mau_req_ack) begin
                    core_req_ack = 1'b1;
                    w_wr_hit     = r_hit;
                    w_touch      = r_hit;
                    w_nxt        = S_IDLE;
                end
            end
            S_NC: begin
                mau_req_val   = 1'b1;
                mau_req_nc    = 1'b1;
                mau_req_we    = (w_cop == COP_WRNC);
                mau_req_addr  = {core_req_addr[ADDR_W-1:2], 2'b00};
                mau_req_wdata = core_req_wdata;
                mau_req_be    = w_be;
                if (mau_req_ack) begin
                    core_req_ack  = 1'b1;
                    core_ack_data = mau_ack_data[31:0];
                    w_nxt         = S_IDLE;
                end
            end
`ifdef L1D_FLUSH_EN
            S_FLUSH: begin
                if (r_fidx == IW'(SETS - 1)) begin
                    flush_done = 1'b1;
                    w_nxt      = S_IDLE;
                end
            end
`endif
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hit_vec <= '0;
            r_inv_vec <= '0;
            r_way     <= '0;
            r_hit     <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (r_state == S_IDLE) begin
                r_hit_vec <= w_hit_vec;
                r_inv_vec <= w_inv_vec;
            end
            if (r_state == S_LOOKUP) begin
                r_hit <= |r_hit_vec;
                r_way <= (|r_hit_vec) ? w_hit_way : w_victim;
            end
        end
    end

`ifdef L1D_FLUSH_EN
    always_ff @(posedge clk) begin
        if (rst || r_state != S_FLUSH)
            r_fidx <= '0;
        else
            r_fidx <= r_fidx + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++)
                r_valid[w] <= '0;
        end else begin
            if (w_fill)
                r_valid[r_way][w_idx] <= 1'b1;
            if (w_clr_val)
                for (int w = 0; w < WAYS; w++)
                    r_valid[w][w_clr_idx] <= 1'b0;
        end
    end

    // Tag/data need no reset: a line is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_fill) begin
                r_tag[r_way][w_idx]  <= w_tag;
                r_data[r_way][w_idx] <= mau_ack_data;
            end
            if (w_wr_hit)
                for (int b = 0; b < 4; b++)
                    if (w_be[b])
                        r_data[r_way][w_idx][32*w_wsel + 8*b +: 8] <=
                            core_req_wdata[8*b +: 8];
        end
    end

    l1d_plru #(
        .WAYS(WAYS),
        .SETS(SETS)
    ) u_plru (
        .clk          (clk),
        .i_clr_all    (rst),
        .i_idx        (w_idx),
        .i_touch_val  (w_touch),
        .i_touch_way  (w_touch_way),
        .i_clr_val    (w_clr_val),
        .i_clr_idx    (w_clr_idx),
        .o_victim_way (w_plru_vic)
    );

endmodule

// File: tb/tb_l1d_cache_sa.sv
// Directed bench for l1d_cache_sa: core driver, MAU memory stub, queue scoreboard.
// Flush scenario is compiled in when L1D_FLUSH_EN is defined.
module tb_l1d_cache_sa;

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, RDNC = 2'd2, WRNC = 2'd3;

    typedef struct {
        logic [31:0] data;
        bit          chk;
        string       nm;
    } ack_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        nc;
        logic [3:0]  be;
        bit          chk_be;
        string       nm;
    } mau_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         core_req_val;
    logic [31:0]  core_req_addr;
    logic [1:0]   core_req_cop;
    logic [31:0]  core_req_wdata;
    logic [1:0]   core_req_size;
    logic         core_req_ack;
    logic [31:0]  core_ack_data;
    logic         mau_req_val;
    logic         mau_req_nc;
    logic         mau_req_we;
    logic [31:0]  mau_req_addr;
    logic [31:0]  mau_req_wdata;
    logic [3:0]   mau_req_be;
    logic         mau_req_ack;
    logic [127:0] mau_ack_data;
`ifdef L1D_FLUSH_EN
    logic         flush_req;
    logic         flush_done;
`endif

    int   n_chk = 0;
    int   n_err = 0;
    bit   mau_hold = 1'b0;
    ack_t aq[$];
    mau_t mq[$];
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    l1d_cache_sa dut (
        .clk            (clk),
        .rst            (rst),
`ifdef L1D_FLUSH_EN
        .flush_req      (flush_req),
        .flush_done     (flush_done),
`endif
        .core_req_val   (core_req_val),
        .core_req_addr  (core_req_addr),
        .core_req_cop   (core_req_cop),
        .core_req_wdata (core_req_wdata),
        .core_req_size  (core_req_size),
        .core_req_ack   (core_req_ack),
        .core_ack_data  (core_ack_data),
        .mau_req_val    (mau_req_val),
        .mau_req_nc     (mau_req_nc),
        .mau_req_we     (mau_req_we),
        .mau_req_addr   (mau_req_addr),
        .mau_req_wdata  (mau_req_wdata),
        .mau_req_be     (mau_req_be),
        .mau_req_ack    (mau_req_ack),
        .mau_ack_data   (mau_ack_data)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic exp_ack(input logic [31:0] d, input bit c, input string nm);
        ack_t e;
        e.data = d; e.chk = c; e.nm = nm;
        aq.push_back(e);
    endtask

    task automatic exp_mau(input logic [31:0] a, input logic we, input logic nc,
                           input logic [3:0] be, input bit cb, input string nm);
        mau_t m;
        m.addr = a; m.we = we; m.nc = nc; m.be = be; m.chk_be = cb; m.nm = nm;
        mq.push_back(m);
    endtask

    // Core driver: holds the request until ack, optionally checks hit latency.
    task automatic do_req(input logic [1:0] cop, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz,
                          input int exp_lat, input string nm);
        int n;
        bit got;
        core_req_cop   = cop;
        core_req_addr  = addr;
        core_req_wdata = wd;
        core_req_size  = sz;
        core_req_val   = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (core_req_ack) got = 1'b1;
        end
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: actual=no_ack required=ack", nm);
        end else if (exp_lat > 0) begin
            chk({nm, "_lat"}, n, exp_lat);
        end
        @(posedge clk);
        #1;
        core_req_val = 1'b0;
    endtask

    // Monitor: every core ack pops one expected response.
    always @(negedge clk) begin
        if (!rst && core_req_ack) begin
            if (aq.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL unexpected_ack: actual=%h required=none",
                         core_ack_data);
            end else begin
                ack_t e;
                e = aq.pop_front();
                if (e.chk) chk(e.nm, core_ack_data, e.data);
            end
        end
    end

    // MAU stub: checks each request against the queue, answers one cycle later.
    initial begin
        mau_req_ack  = 1'b0;
        mau_ack_data = '0;
        forever begin
            @(negedge clk);
            if (!rst && mau_req_val && !mau_hold) begin
                logic [31:0] a;
                logic [31:0] t;
                if (mq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_mau: actual=%h required=none",
                             mau_req_addr);
                end else begin
                    mau_t m;
                    m = mq.pop_front();
                    chk({m.nm, "_addr"}, mau_req_addr, m.addr);
                    chk({m.nm, "_we"}, 32'(mau_req_we), 32'(m.we));
                    chk({m.nm, "_nc"}, 32'(mau_req_nc), 32'(m.nc));
                    if (m.chk_be) chk({m.nm, "_be"}, 32'(mau_req_be), 32'(m.be));
                end
                a = mau_req_addr;
                @(posedge clk);
                #1;
                if (mau_req_we) begin
                    t = mem_rd(a);
                    for (int b = 0; b < 4; b++)
                        if (mau_req_be[b]) t[8*b +: 8] = mau_req_wdata[8*b +: 8];
                    mem[a] = t;
                    mau_ack_data = '0;
                end else if (mau_req_nc) begin
                    mau_ack_data = {96'h0, mem_rd(a)};
                end else begin
                    for (int i = 0; i < 4; i++)
                        mau_ack_data[32*i +: 32] = mem_rd((a & 32'hFFFF_FFF0) + 32'(4*i));
                end
                mau_req_ack = 1'b1;
                @(posedge clk);
                #1;
                mau_req_ack  = 1'b0;
                mau_ack_data = '0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;
        rst = 1'b1;
        core_req_val = 1'b0;
        core_req_addr = '0;
        core_req_cop = RD;
        core_req_wdata = '0;
        core_req_size = 2'd0;
`ifdef L1D_FLUSH_EN
        flush_req = 1'b0;
`endif
        mem[32'h1044] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(core_req_ack), 0);
        chk("rst_mau_val", 32'(mau_req_val), 0);
        chk("rst_mau_nc", 32'(mau_req_nc), 0);
        chk("rst_mau_we", 32'(mau_req_we), 0);
        chk("rst_ack_data", core_ack_data, 0);
        chk("rst_mau_addr", mau_req_addr, 0);
`ifdef L1D_FLUSH_EN
        chk("rst_flush_done", 32'(flush_done), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        exp_mau(32'h1040, 0, 0, 4'hF, 0, "cold_refill");
        exp_ack(32'hC0DE_1040, 1, "cold_rd");
        do_req(RD, 32'h1040, 0, 2'd0, 0, "cold_rd");

        exp_ack(32'hDEAD_BEEF, 1, "hit_rd_1044");
        do_req(RD, 32'h1044, 0, 2'd0, 2, "hit_rd_1044");

        exp_mau(32'h1044, 1, 0, 4'b0010, 1, "wr_byte");
        exp_ack(0, 0, "wr_byte");
        do_req(WR, 32'h1045, 32'h0000_AA00, 2'd1, 0, "wr_byte");
        exp_ack(32'hDEAD_AAEF, 1, "rd_after_byte");
        do_req(RD, 32'h1044, 0, 2'd0, 2, "rd_after_byte");

        exp_mau(32'h1044, 1, 0, 4'b1100, 1, "wr_half");
        exp_ack(0, 0, "wr_half");
        do_req(WR, 32'h1046, 32'hBBCC_0000, 2'd2, 0, "wr_half");
        exp_ack(32'hBBCC_AAEF, 1, "rd_after_half");
        do_req(RD, 32'h1044, 0, 2'd0, 2, "rd_after_half");

        exp_mau(32'h2000, 1, 0, 4'hF, 1, "wr_miss");
        exp_ack(0, 0, "wr_miss");
        do_req(WR, 32'h2000, 32'h5566_7788, 2'd0, 0, "wr_miss");
        exp_mau(32'h2000, 0, 0, 4'hF, 0, "no_alloc_refill");
        exp_ack(32'h5566_7788, 1, "no_alloc_rd");
        do_req(RD, 32'h2000, 0, 2'd0, 0, "no_alloc_rd");

        // Set 5: fill four ways, fifth tag evicts the pLRU way (tag 1).
        for (int t = 1; t <= 5; t++) begin
            logic [31:0] a;
            a = 32'(t) * 32'h400 + 32'h50;
            exp_mau(a, 0, 0, 4'hF, 0, "plru_fill");
            exp_ack(32'hC0DE_0000 | a, 1, "plru_fill_rd");
            do_req(RD, a, 0, 2'd0, 0, "plru_fill_rd");
        end
        exp_ack(32'hC0DE_0850, 1, "plru_hit_t2");
        do_req(RD, 32'h0850, 0, 2'd0, 2, "plru_hit_t2");
        exp_ack(32'hC0DE_0C50, 1, "plru_hit_t3");
        do_req(RD, 32'h0C50, 0, 2'd0, 2, "plru_hit_t3");
        exp_ack(32'hC0DE_1050, 1, "plru_hit_t4");
        do_req(RD, 32'h1050, 0, 2'd0, 2, "plru_hit_t4");
        exp_mau(32'h0450, 0, 0, 4'hF, 0, "plru_evicted");
        exp_ack(32'hC0DE_0450, 1, "plru_evicted_rd");
        do_req(RD, 32'h0450, 0, 2'd0, 0, "plru_evicted_rd");

        exp_mau(32'h1040, 1, 1, 4'hF, 1, "wrnc");
        exp_ack(0, 0, "wrnc");
        do_req(WRNC, 32'h1040, 32'h1234_5678, 2'd0, 0, "wrnc");
        exp_mau(32'h1040, 0, 1, 4'hF, 1, "rdnc");
        exp_ack(32'h1234_5678, 1, "rdnc");
        do_req(RDNC, 32'h1040, 0, 2'd0, 0, "rdnc");
        exp_ack(32'hC0DE_1040, 1, "rd_after_nc");
        do_req(RD, 32'h1040, 0, 2'd0, 2, "rd_after_nc");

        // Reset while the refill is outstanding.
        mau_hold = 1'b1;
        core_req_cop = RD;
        core_req_addr = 32'h3000;
        core_req_size = 2'd0;
        core_req_val = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (mau_req_val) got = 1'b1;
        end
        chk("abort_refill_seen", 32'(got), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        core_req_val = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_mau_val", 32'(mau_req_val), 0);
        chk("abort_ack", 32'(core_req_ack), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mau_hold = 1'b0;

        exp_mau(32'h1040, 0, 0, 4'hF, 0, "post_rst_refill");
        exp_ack(32'h1234_5678, 1, "post_rst_rd");
        do_req(RD, 32'h1040, 0, 2'd0, 0, "post_rst_rd");
        exp_mau(32'h3000, 0, 0, 4'hF, 0, "refill_3000");
        exp_ack(32'hC0DE_3000, 1, "rd_3000");
        do_req(RD, 32'h3000, 0, 2'd0, 0, "rd_3000");
        exp_ack(32'hC0DE_3000, 1, "hit_3000");
        do_req(RD, 32'h3000, 0, 2'd0, 2, "hit_3000");

`ifdef L1D_FLUSH_EN
        exp_mau(32'h3000, 0, 0, 4'hF, 0, "flush_refill");
        exp_ack(32'hC0DE_3000, 1, "flush_rd");
        core_req_cop = RD;
        core_req_addr = 32'h3000;
        core_req_size = 2'd0;
        core_req_val = 1'b1;
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (flush_done) got = 1'b1;
        end
        chk("flush_done_seen", 32'(got), 1);
        chk("flush_cycles", n, 64);
        @(negedge clk);
        chk("flush_done_pulse", 32'(flush_done), 0);
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            if (core_req_ack) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("flush_rd_ack_seen", 32'(got), 1);
        @(posedge clk);
        #1;
        core_req_val = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("ack_queue_empty", aq.size(), 0);
        chk("mau_queue_empty", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/l1d_cache_sa.md
Name: l1d_cache_sa

Overview:
Parametrised successor of the L1 data cache: set-associative, write-through, no-write-allocate. It sits between the core LSU port and the MAU. Ways, sets and line size are configurable, and an explicit FSM handles hit, refill, write-through and non-cacheable (NC) bypass. A pseudo-LRU tree selects the victim, with invalid ways preferred.

Parameters:
WAYS, 4, associativity; power of 2, 1..8 (1 = direct-mapped, victim always way 0)
SETS, 64, sets per way; power of 2, >= 2
LINE_BYTES, 16, line size in bytes; power of 2, 4..64
ADDR_W, 32, core address width

Ports:
clk  in  1  clock
rst  in  1  reset
core_req_val  in  1  request valid; held with all fields stable until core_req_ack
core_req_addr  in  ADDR_W  byte address; naturally aligned to size
core_req_cop  in  2  0=RD, 1=WR, 2=RDNC, 3=WRNC
core_req_wdata  in  32  write data, already placed in its byte lanes
core_req_size  in  2  1=byte, 2=half, other=word
core_req_ack  out  1  one-cycle completion pulse
core_ack_data  out  32  full aligned word containing the address; valid with ack on reads
mau_req_val  out  1  MAU request; held until mau_req_ack
mau_req_nc  out  1  non-cacheable
mau_req_we  out  1  write
mau_req_addr  out  ADDR_W  line-aligned for cacheable reads; word-aligned otherwise
mau_req_wdata  out  32  equals core_req_wdata
mau_req_be  out  4  byte lanes: size mask shifted left by addr[1:0]
mau_req_ack  in  1  MAU completion
mau_ack_data  in  LINE_BYTES*8  refill line; NC read word in bits [31:0]

Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset
  - FSM goes to IDLE; all valid bits and pLRU bits clear.
  - core_req_ack, mau_req_val, mau_req_nc and mau_req_we are 0.
  - Data outputs are 0.
- Reset mid-operation (e.g. during REFILL)
  - Abort to IDLE; mau_req_val is 0 the next cycle.
  - No array writes occur that cycle.
- Address split: {tag, idx[log2 SETS], offset[log2 LINE_BYTES]}.
- FSM states: IDLE, LOOKUP, REFILL, WTHRU, NC.
- IDLE
  - core_req_val with RD/WR: latch tag-read results, go to LOOKUP.
  - core_req_val with RDNC/WRNC: go to NC.
- LOOKUP: hit = tag match && valid; at most one way may hit.
  - RD hit: core_req_ack=1 with the word from the hit way; pLRU touched; back to IDLE. Read-hit latency is 2 cycles from val.
  - RD miss: go to REFILL; victim = lowest invalid way, else pLRU victim, registered.
  - WR: go to WTHRU; hit way registered.
- REFILL
  - mau_req_val=1, we=0, nc=0, line-aligned addr.
  - On mau_req_ack, in the same cycle:
    - write the line into the victim way;
    - set valid and tag;
    - touch pLRU;
    - core_req_ack=1 with the word taken from mau_ack_data;
    - go to IDLE.
- WTHRU
  - mau_req_val=1, we=1, nc=0, word-aligned addr, be per size/offset.
  - On mau_req_ack: core_req_ack=1.
  - On hit: byte-masked write to the hit way and pLRU touched.
  - On miss: no array change (no allocate).
- NC
  - mau_req_val=1, nc=1, we = (cop==WRNC).
  - On mau_req_ack: core_req_ack=1 and core_ack_data = mau_ack_data[31:0].
  - Cache arrays and pLRU are untouched.
- Request acceptance: no new request is accepted in the ack cycle; the next request is sampled in IDLE the following cycle.
- Storage: arrays are register-based with combinational read on idx.
- Back-to-back access: a RD to a line refilled in the previous request hits.
- pLRU: tree of WAYS-1 bits per set; a touch points the tree away from the accessed way.

Optional Feature:
Macro L1D_FLUSH_EN.
- With the macro:
  - Adds ports flush_req (in, 1) and flush_done (out, 1, reset 0).
  - flush_req sampled in IDLE moves the FSM to FLUSH. flush_req has priority over a simultaneous core_req_val, which waits.
  - FLUSH clears the valid and pLRU bits of one set per cycle, idx 0..SETS-1, taking SETS cycles.
  - flush_done pulses 1 cycle on the last set; the FSM then returns to IDLE.
  - Reset during FLUSH aborts it; all valid bits clear anyway.
- Without the macro: no flush ports and no FLUSH state.

Decomposition:
- Package l1d_cache_pkg holds:
  - cop enum (RD/WR/RDNC/WRNC);
  - FSM state enum;
  - size encodings;
  - functions be_from_size(size, off) and onehot_to_idx.
- Sub-module l1d_plru (params WAYS, SETS):
  - inputs idx, touch_val, touch_way, clr_all, clr_idx/clr_val;
  - output victim_way.

Test Plan:
- Cold RD 0x0000_1040 (WAYS=4, LINE_BYTES=16): REFILL with mau_req_addr=0x1040; the MAU returns a line with word1=0xDEAD_BEEF. A RD of 0x1044 -> ack with 0xDEADBEEF and no mau_req_val.
- WR hit, byte at 0x1045, wdata=0x0000_AA00: mau_req_be=4'b0010, addr=0x1044. A later RD of 0x1044 -> 0xDEADAAEF.
- WR miss to 0x2000: MAU write issued. A subsequent RD of 0x2000 -> REFILL, proving no allocate.
- Five reads with the same idx and distinct tags (WAYS=4): the fifth evicts the pLRU way. Re-reading the oldest tag misses; the other three hit.
- RDNC 0x1040 after it is cached: mau_req_nc=1 and the data comes from the MAU. A RD of 0x1040 then still hits with the old data.
- L1D_FLUSH_EN, flush_req asserted together with core_req_val (SETS=64): flush_done after 64 cycles, then the core RD of a previously cached line misses.
